// File: rtl/ps2_direction_rx_if.sv
// PS/2 keyboard receiver bus: PS/2 line inputs plus decoded scan and direction outputs.
// The slave modport is the receiver side; the master modport is the keyboard/consumer side.
interface ps2_direction_rx_if;
  logic       ps2c;
  logic       ps2d;
  logic [1:0] dir;
  logic       dir_valid;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2c,
    output ps2d,
    input  dir,
    input  dir_valid,
    input  scan_code,
    input  scan_valid,
    input  frame_err
  );

  modport slave (
    input  ps2c,
    input  ps2d,
    output dir,
    output dir_valid,
    output scan_code,
    output scan_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver that decodes extended arrow-key make codes into a 2-bit direction.
// Frames are start(0), 8 data bits LSB first, odd parity, stop(1), sampled on filtered falling
// PS2C edges. Define PS2_PARITY_CHECK_EN to reject frames with bad parity; by default the
// parity bit is consumed but its value is ignored.
module ps2_direction_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input logic               mclk,
  input logic               reset,
  ps2_direction_rx_if.slave bus
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TmoW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             filt_clk_q, filt_clk_d;
  logic             fall;
  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             timeout;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [1:0]       dir_q, dir_d;
  logic             dir_valid_q, dir_valid_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             scan_valid_q, scan_valid_d;
  logic             frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic             par_q, par_d;
`endif

  // Two-flop synchronizers for the asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge mclk) begin
    if (reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
    end else begin
      ps2c_meta_q <= bus.ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= bus.ps2d;
      ps2d_sync_q <= ps2d_meta_q;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (ps2c_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_clk_d = ps2c_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall    = filt_clk_q & ~filt_clk_d;
  assign timeout = (state_q != StIdle) && !fall && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  // Frame FSM, timeout, prefix tracking and registered output next-state.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    dir_d        = dir_q;
    scan_code_d  = scan_code_q;
    dir_valid_d  = 1'b0;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (fall && !ps2d_sync_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {ps2d_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        // Without the parity check the bit is consumed here and its value dropped.
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = ps2d_sync_q;
`endif
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
`ifdef PS2_PARITY_CHECK_EN
          if (!ps2d_sync_q || !(^{shift_q, par_q})) begin
`else
          if (!ps2d_sync_q) begin
`endif
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              if (ext_q && !brk_q) begin
                case (shift_q)
                  8'h74:   begin dir_d = 2'd0; dir_valid_d = 1'b1; end
                  8'h75:   begin dir_d = 2'd1; dir_valid_d = 1'b1; end
                  8'h6B:   begin dir_d = 2'd2; dir_valid_d = 1'b1; end
                  8'h72:   begin dir_d = 2'd3; dir_valid_d = 1'b1; end
                  default: ;
                endcase
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A stalled partial frame is abandoned and the prefix state is cleared.
    if (timeout) begin
      state_d     = StIdle;
      bit_cnt_d   = '0;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      filt_cnt_q   <= '0;
      filt_clk_q   <= 1'b1;
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      dir_q        <= 2'd0;
      dir_valid_q  <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      filt_cnt_q   <= filt_cnt_d;
      filt_clk_q   <= filt_clk_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      dir_q        <= dir_d;
      dir_valid_q  <= dir_valid_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.dir        = dir_q;
  assign bus.dir_valid  = dir_valid_q;
  assign bus.scan_code  = scan_code_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule
